// File: rtl/logic_result_skid.sv
// Two-entry skid buffer registering the bitwise logic unit result with a zero flag and
// saturating accepted-result counter. Optional per-entry parity enabled by LRS_PARITY_EN.
module logic_result_skid #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_o,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_o,
    output logic             out_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] res_cnt,
    output logic             out_par
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] skid_o;
    logic             skid_zero;
    logic             push;
    logic             pop;
    logic             load_head_in;
    logic             load_head_skid;
    logic             load_skid;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Head takes new data directly unless an older entry is still ahead of it.
    assign load_head_in   = push & ((state == EMPTY) | ((state == ONE) & pop));
    assign load_skid      = push & (state == ONE) & ~pop;
    assign load_head_skid = pop & (state == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != FULL);
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            EMPTY: if (push) next_state = ONE;
            ONE: begin
                if (push && !pop)      next_state = FULL;
                else if (pop && !push) next_state = EMPTY;
            end
            FULL:  if (pop) next_state = ONE;
            default: next_state = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state != EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_o     <= '0;
            out_zero  <= 1'b0;
            skid_o    <= '0;
            skid_zero <= 1'b0;
        end else begin
            if (load_head_in) begin
                out_o    <= in_o;
                out_zero <= (in_o == '0);
            end else if (load_head_skid) begin
                out_o    <= skid_o;
                out_zero <= skid_zero;
            end
            if (load_skid) begin
                skid_o    <= in_o;
                skid_zero <= (in_o == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_cnt <= '0;
        end else if (push && (res_cnt != '1)) begin
            res_cnt <= res_cnt + 1'b1;
        end
    end

`ifdef LRS_PARITY_EN
    logic skid_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par  <= 1'b0;
            skid_par <= 1'b0;
        end else begin
            if (load_head_in)        out_par <= ^in_o;
            else if (load_head_skid) out_par <= skid_par;
            if (load_skid)           skid_par <= ^in_o;
        end
    end
`else
    assign out_par = 1'b0;
`endif

endmodule

// File: tb/tb_logic_result_skid.sv
// Randomized self-checking bench for logic_result_skid against a queue-based FIFO model.
module tb_logic_result_skid;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_o = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_o;
    logic        out_zero;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] res_cnt;
    logic        out_par;

    logic [31:0] in_o4 = '0;
    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [31:0] out_o4;
    logic        out_zero4;
    logic        out_valid4;
    logic        out_ready4 = 1'b0;
    logic [3:0]  res_cnt4;
    logic        out_par4;

`ifdef LRS_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    logic [31:0] q[$];
    int cnt = 0;
    int cnt4 = 0;

    always #5 clk = ~clk;

    logic_result_skid #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_o(in_o), .in_valid(in_valid), .in_ready(in_ready),
        .out_o(out_o), .out_zero(out_zero), .out_valid(out_valid), .out_ready(out_ready),
        .res_cnt(res_cnt), .out_par(out_par)
    );

    logic_result_skid #(.WIDTH(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_o(in_o4), .in_valid(in_valid4), .in_ready(in_ready4),
        .out_o(out_o4), .out_zero(out_zero4), .out_valid(out_valid4), .out_ready(out_ready4),
        .res_cnt(res_cnt4), .out_par(out_par4)
    );

    function automatic logic exp_par(input logic [31:0] d);
        return (^d) & PAR_EN;
    endfunction

    // Drive one cycle on the main instance and advance the FIFO model at the edge.
    task automatic step(input logic v, input logic [31:0] d, input logic r);
        bit pu;
        bit po;
        in_valid  = v;
        in_o      = d;
        out_ready = r;
        @(posedge clk);
        pu = v && (q.size() < 2);
        po = r && (q.size() > 0);
        if (po) void'(q.pop_front());
        if (pu) begin
            q.push_back(d);
            if (cnt < 65535) cnt++;
        end
        @(negedge clk);
    endtask

    task automatic step4(input logic v, input logic [31:0] d);
        in_valid4  = v;
        in_o4      = d;
        out_ready4 = 1'b1;
        @(posedge clk);
        if (v && in_ready4 === 1'b1 && cnt4 < 15) cnt4++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        q.delete();
        cnt = 0;
        total += 6;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (res_cnt !== 16'd0) begin bad++; $display("FAIL reset_res_cnt got=%0d exp=0", res_cnt); end
        if (out_o !== 32'd0) begin bad++; $display("FAIL reset_out_o got=%h exp=0", out_o); end
        if (out_zero !== 1'b0) begin bad++; $display("FAIL reset_out_zero got=%b exp=0", out_zero); end
        if (out_par !== 1'b0) begin bad++; $display("FAIL reset_out_par got=%b exp=0", out_par); end
        rst_n = 1'b1;
        step(1'b0, 32'h0, 1'b0);
        total += 3;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL release_out_valid got=%b exp=0", out_valid); end
        if (res_cnt !== 16'd0) begin bad++; $display("FAIL release_res_cnt got=%0d exp=0", res_cnt); end
    endtask

    task automatic test_single();
        step(1'b1, 32'hF0F0_00FF, 1'b1);
        total += 4;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        if (out_o !== 32'hF0F0_00FF) begin bad++; $display("FAIL single_data got=%h exp=f0f000ff", out_o); end
        if (out_zero !== 1'b0) begin bad++; $display("FAIL single_zero got=%b exp=0", out_zero); end
        if (res_cnt !== 16'd1) begin bad++; $display("FAIL single_cnt got=%0d exp=1", res_cnt); end
        step(1'b0, 32'h0, 1'b1);
        total += 1;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL single_valid_drop got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        step(1'b1, 32'h0000_0000, 1'b0);
        total += 3;
        if (out_zero !== 1'b1) begin bad++; $display("FAIL bp_zero_flag got=%b exp=1", out_zero); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_one got=%b exp=1", in_ready); end
        if (out_par !== 1'b0) begin bad++; $display("FAIL bp_par_zero got=%b exp=0", out_par); end
        step(1'b1, 32'h1234_5678, 1'b0);
        total += 2;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b exp=0", in_ready); end
        if (out_o !== 32'h0) begin bad++; $display("FAIL bp_head_hold got=%h exp=0", out_o); end
        step(1'b1, 32'hDEAD_BEEF, 1'b0);
        total += 3;
        if (res_cnt !== 16'(cnt)) begin bad++; $display("FAIL bp_no_accept_cnt got=%0d exp=%0d", res_cnt, cnt); end
        if (out_o !== 32'h0) begin bad++; $display("FAIL bp_stable got=%h exp=0", out_o); end
        if (q.size() != 2) begin bad++; $display("FAIL bp_model_occ got=%0d exp=2", q.size()); end
        step(1'b0, 32'h0, 1'b1);
        total += 3;
        if (out_o !== 32'h1234_5678) begin bad++; $display("FAIL bp_second got=%h exp=12345678", out_o); end
        if (out_zero !== 1'b0) begin bad++; $display("FAIL bp_second_zero got=%b exp=0", out_zero); end
        if (out_par !== exp_par(32'h1234_5678)) begin bad++; $display("FAIL bp_second_par got=%b exp=%b", out_par, exp_par(32'h1234_5678)); end
        step(1'b0, 32'h0, 1'b1);
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
        if (out_o !== 32'h1234_5678) begin bad++; $display("FAIL bp_keep_last got=%h exp=12345678", out_o); end
    endtask

    task automatic test_streaming();
        int start;
        start = cnt;
        for (int i = 1; i <= 100; i++) begin
            step(1'b1, 32'(i), 1'b1);
            total += 3;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready i=%0d got=%b exp=1", i, in_ready); end
            if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_gap i=%0d got=%b exp=1", i, out_valid); end
            if (out_o !== 32'(i)) begin bad++; $display("FAIL stream_order i=%0d got=%h exp=%h", i, out_o, 32'(i)); end
        end
        total += 1;
        if (res_cnt !== 16'(start + 100)) begin bad++; $display("FAIL stream_cnt got=%0d exp=%0d", res_cnt, start + 100); end
        step(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_async_reset();
        step(1'b1, 32'hAAAA_0001, 1'b0);
        step(1'b1, 32'hAAAA_0002, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        cnt = 0;
        total += 3;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b exp=1", in_ready); end
        if (out_o !== 32'h0) begin bad++; $display("FAIL arst_data got=%h exp=0", out_o); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b1);
            total += 1;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_stale i=%0d got=%b exp=0", i, out_valid); end
        end
        step(1'b1, 32'h0000_0007, 1'b0);
        total += 3;
        if (out_o !== 32'h7) begin bad++; $display("FAIL arst_fresh got=%h exp=7", out_o); end
        if (out_par !== PAR_EN) begin bad++; $display("FAIL parity7 got=%b exp=%b", out_par, PAR_EN); end
        if (res_cnt !== 16'd1) begin bad++; $display("FAIL arst_cnt got=%0d exp=1", res_cnt); end
        step(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 20; i++) begin
            step4(1'b1, $urandom);
            if (i == 13) begin
                total += 1;
                if (res_cnt4 !== 4'd14) begin bad++; $display("FAIL sat_pre got=%0d exp=14", res_cnt4); end
            end
        end
        total += 2;
        if (res_cnt4 !== 4'(cnt4)) begin bad++; $display("FAIL sat_model got=%0d exp=%0d", res_cnt4, cnt4); end
        if (res_cnt4 !== 4'd15) begin bad++; $display("FAIL sat_cnt got=%0d exp=15", res_cnt4); end
        step4(1'b0, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic        v;
        logic        r;
        for (int i = 0; i < 400; i++) begin
            v = 1'($urandom_range(0, 3) != 0);
            r = 1'($urandom_range(0, 2) != 0);
            d = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
            step(v, d, r);
            total += 3;
            if (in_ready !== logic'(q.size() < 2)) begin bad++; $display("FAIL rand_ready i=%0d got=%b exp=%b", i, in_ready, q.size() < 2); end
            if (out_valid !== logic'(q.size() > 0)) begin bad++; $display("FAIL rand_valid i=%0d got=%b exp=%b", i, out_valid, q.size() > 0); end
            if (res_cnt !== 16'(cnt)) begin bad++; $display("FAIL rand_cnt i=%0d got=%0d exp=%0d", i, res_cnt, cnt); end
            if (q.size() > 0) begin
                total += 3;
                if (out_o !== q[0]) begin bad++; $display("FAIL rand_data i=%0d got=%h exp=%h", i, out_o, q[0]); end
                if (out_zero !== logic'(q[0] == 32'h0)) begin bad++; $display("FAIL rand_zero i=%0d got=%b exp=%b", i, out_zero, q[0] == 32'h0); end
                if (out_par !== exp_par(q[0])) begin bad++; $display("FAIL rand_par i=%0d got=%b exp=%b", i, out_par, exp_par(q[0])); end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_async_reset();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
